// File: rtl/bsg_fsb_trace_recorder.sv
// FSB packet trace recorder: per-channel delay stamping, one staging slot per
// channel, round-robin drain into a circular trace buffer read out via valid/yumi.
module bsg_fsb_trace_recorder #(
    parameter int width_p          = 80,
    parameter int channels_p       = 2,
    parameter int els_p            = 16,
    parameter int counter_width_p  = 16,
    parameter int wrap_p           = 0,
    localparam int ch_w            = (channels_p > 1) ? $clog2(channels_p) : 1,
    localparam int entry_w         = ch_w + counter_width_p + width_p
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          en_i,
    input  logic [channels_p-1:0]         fire_i,
    input  logic [channels_p*width_p-1:0] data_i,
    output logic                          v_o,
    output logic [entry_w-1:0]            data_o,
    input  logic                          yumi_i,
    output logic [counter_width_p-1:0]    drop_count_o,
    output logic                          overflow_o
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);
    localparam int dn_w  = $clog2(channels_p + 2);

    logic [channels_p-1:0] hold_v;
    logic [channels_p-1:0] grant_oh;
    logic [channels_p-1:0] stage_drop;
    logic [entry_w-1:0]    hold_data [channels_p];

    logic                  grant_v;
    logic [ch_w-1:0]       grant_ch;
    logic [entry_w-1:0]    grant_entry;
    logic [ch_w-1:0]       rr_q, rr_d;
    int                    arb_idx;

    logic [ptr_w-1:0]      wptr_q, wptr_d;
    logic [ptr_w-1:0]      rptr_q, rptr_d;
    logic [cnt_w-1:0]      count_q, count_d;
    logic [entry_w-1:0]    mem_q [els_p];
    logic                  buf_full;
    logic                  buf_accept;
    logic                  wrap_drop;

    logic [counter_width_p-1:0]      drop_q, drop_d;
    logic                            ovf_q, ovf_d;
    logic [dn_w-1:0]                 drop_n;
    logic [counter_width_p+dn_w-1:0] drop_sum;

    // Per-channel delay counter and staging slot
    for (genvar gi = 0; gi < channels_p; gi++) begin : g_ch
        logic [counter_width_p-1:0] delay_q, delay_d;
        logic                       hv_q, hv_d;
        logic [entry_w-1:0]         hd_q, hd_d;
        logic                       capture;
        logic                       load;

        always_comb begin
            delay_d = delay_q;
            hv_d    = hv_q;
            hd_d    = hd_q;
            capture = en_i & fire_i[gi];
            // A slot being granted this cycle frees up in time to take the new fire
            load    = capture & (~hv_q | grant_oh[gi]);
            if (en_i) begin
                if (fire_i[gi]) begin
                    delay_d = '0;
                end else if (delay_q != '1) begin
                    delay_d = delay_q + 1'b1;
                end
            end
            if (load) begin
                hv_d = 1'b1;
                hd_d = {ch_w'(gi), delay_q, data_i[gi*width_p +: width_p]};
            end else if (grant_oh[gi]) begin
                hv_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                delay_q <= '0;
                hv_q    <= 1'b0;
            end else begin
                delay_q <= delay_d;
                hv_q    <= hv_d;
            end
            hd_q <= hd_d;
        end

        assign hold_v[gi]     = hv_q;
        assign hold_data[gi]  = hd_q;
        assign stage_drop[gi] = capture & ~load;
    end

    assign buf_full   = (count_q == cnt_w'(els_p));
    assign buf_accept = ~buf_full | yumi_i | (wrap_p != 0);

    // Round-robin arbiter starting at rr_q
    always_comb begin
        grant_v  = 1'b0;
        grant_ch = '0;
        grant_oh = '0;
        arb_idx  = 0;
        if (buf_accept) begin
            for (int i = 0; i < channels_p; i++) begin
                arb_idx = int'(rr_q) + i;
                if (arb_idx >= channels_p) begin
                    arb_idx = arb_idx - channels_p;
                end
                if (!grant_v && hold_v[arb_idx[ch_w-1:0]]) begin
                    grant_v  = 1'b1;
                    grant_ch = arb_idx[ch_w-1:0];
                end
            end
        end
        if (grant_v) begin
            grant_oh[grant_ch] = 1'b1;
        end
    end

    assign grant_entry = hold_data[grant_ch];

    always_comb begin
        rr_d = rr_q;
        if (grant_v) begin
            rr_d = (grant_ch == ch_w'(channels_p - 1)) ? '0 : grant_ch + 1'b1;
        end
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        wrap_drop = 1'b0;
        if (grant_v) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (yumi_i) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (grant_v && !yumi_i && buf_full) begin
            // Only reachable when wrapping: the oldest entry is overwritten
            rptr_d    = rptr_q + 1'b1;
            wrap_drop = 1'b1;
        end else if (grant_v && !yumi_i) begin
            count_d = count_q + 1'b1;
        end else if (!grant_v && yumi_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < channels_p; i++) begin
            drop_n = drop_n + dn_w'(stage_drop[i]);
        end
        drop_n   = drop_n + dn_w'(wrap_drop);
        drop_sum = {{dn_w{1'b0}}, drop_q} + {{counter_width_p{1'b0}}, drop_n};
        if (|drop_sum[counter_width_p +: dn_w]) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[counter_width_p-1:0];
        end
        ovf_d = ovf_q | (drop_n != '0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant_v) begin
            mem_q[wptr_q] <= grant_entry;
        end
    end

    assign v_o          = (count_q != '0);
    assign data_o       = mem_q[rptr_q];
    assign drop_count_o = drop_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_bsg_fsb_trace_recorder.sv
// Scoreboard bench: a stop-mode and a wrap-mode recorder share stimulus; a
// queue-based model predicts entries and drop counts, a monitor compares them.
`timescale 1ns/1ps
module tb_bsg_fsb_trace_recorder;
    localparam int W    = 8;
    localparam int CH   = 2;
    localparam int ELS  = 4;
    localparam int CW   = 4;
    localparam int CHW  = 1;
    localparam int EW   = CHW + CW + W;
    localparam int MAXD = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset = 1'b1;
    logic            en    = 1'b0;
    logic [CH-1:0]   fire  = '0;
    logic [CH*W-1:0] din   = '0;
    logic [1:0]      yumi  = '0;
    logic [1:0]      v;
    logic [1:0]      ovf;
    logic [EW-1:0]   dout0, dout1;
    logic [CW-1:0]   dcnt0, dcnt1;

    bsg_fsb_trace_recorder #(
        .width_p(W), .channels_p(CH), .els_p(ELS), .counter_width_p(CW), .wrap_p(0)
    ) u_stop (
        .clk_i(clk), .reset_i(reset), .en_i(en), .fire_i(fire), .data_i(din),
        .v_o(v[0]), .data_o(dout0), .yumi_i(yumi[0]),
        .drop_count_o(dcnt0), .overflow_o(ovf[0])
    );

    bsg_fsb_trace_recorder #(
        .width_p(W), .channels_p(CH), .els_p(ELS), .counter_width_p(CW), .wrap_p(1)
    ) u_wrap (
        .clk_i(clk), .reset_i(reset), .en_i(en), .fire_i(fire), .data_i(din),
        .v_o(v[1]), .data_o(dout1), .yumi_i(yumi[1]),
        .drop_count_o(dcnt1), .overflow_o(ovf[1])
    );

    // Reference model state (index k: 0 = stop mode, 1 = wrap mode)
    logic [EW-1:0] mbuf  [2][$];
    logic [EW-1:0] exp_q [2][$];
    bit            mhv   [2][CH];
    logic [EW-1:0] mhold [2][CH];
    int            mdly  [2][CH];
    int            mrr   [2];
    int            mdrop [2];
    bit            movf  [2];

    bit            cur_v    [2];
    int            cur_drop [2];
    bit            cur_ovf  [2];

    bit            dir_v_en [2];
    bit            dir_v    [2];
    bit            dir_d_en [2];
    logic [EW-1:0] dir_d    [2];
    bit            dir_drop_en [2];
    int            dir_drop [2];

    bit started = 1'b0;
    int n_cmp   = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input int k, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    // One clock of behaviour for recorder k, using this cycle's inputs
    task automatic model_step(input int k);
        int            g;
        int            drops;
        logic [CHW-1:0] cid;
        if (reset) begin
            mbuf[k].delete();
            mrr[k]   = 0;
            mdrop[k] = 0;
            movf[k]  = 1'b0;
            for (int c = 0; c < CH; c++) begin
                mhv[k][c]  = 1'b0;
                mdly[k][c] = 0;
            end
            return;
        end
        g     = -1;
        drops = 0;
        if (mbuf[k].size() < ELS || yumi[k] || k == 1) begin
            for (int i = 0; i < CH; i++) begin
                if (g < 0 && mhv[k][(mrr[k] + i) % CH]) g = (mrr[k] + i) % CH;
            end
        end
        if (yumi[k]) exp_q[k].push_back(mbuf[k].pop_front());
        if (g >= 0) begin
            mbuf[k].push_back(mhold[k][g]);
            mhv[k][g] = 1'b0;
            mrr[k]    = (g + 1) % CH;
            if (mbuf[k].size() > ELS) begin
                void'(mbuf[k].pop_front());
                drops++;
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (en && fire[c]) begin
                if (mhv[k][c]) begin
                    drops++;
                end else begin
                    cid         = CHW'(c);
                    mhold[k][c] = {cid, CW'(mdly[k][c]), din[c*W +: W]};
                    mhv[k][c]   = 1'b1;
                end
            end
        end
        if (en) begin
            for (int c = 0; c < CH; c++) begin
                if (fire[c]) mdly[k][c] = 0;
                else if (mdly[k][c] < MAXD) mdly[k][c] = mdly[k][c] + 1;
            end
        end
        mdrop[k] = (mdrop[k] + drops > MAXD) ? MAXD : mdrop[k] + drops;
        if (drops > 0) movf[k] = 1'b1;
    endtask

    task automatic drive(input bit r, input bit e, input logic [CH-1:0] f,
                         input logic [CH*W-1:0] d, input int yp);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            cur_v[k]       = (mbuf[k].size() != 0);
            cur_drop[k]    = mdrop[k];
            cur_ovf[k]     = movf[k];
            dir_v_en[k]    = 1'b0;
            dir_d_en[k]    = 1'b0;
            dir_drop_en[k] = 1'b0;
            yumi[k] = !r && v[k] && (mbuf[k].size() != 0) && (int'($urandom_range(99)) < yp);
        end
        reset = r;
        en    = e;
        fire  = f;
        din   = d;
        for (int k = 0; k < 2; k++) model_step(k);
        started = 1'b1;
    endtask

    task automatic expect_v(input int k, input bit val);
        dir_v_en[k] = 1'b1;
        dir_v[k]    = val;
    endtask

    task automatic expect_d(input int k, input logic [EW-1:0] val);
        dir_d_en[k] = 1'b1;
        dir_d[k]    = val;
    endtask

    task automatic expect_drop(input int k, input int val);
        dir_drop_en[k] = 1'b1;
        dir_drop[k]    = val;
    endtask

    // Monitor: compares this cycle's DUT outputs with the pushed expectations
    initial begin : monitor
        logic [EW-1:0] dk;
        logic [CW-1:0] ck;
        forever begin
            @(negedge clk);
            if (started) begin
                for (int k = 0; k < 2; k++) begin
                    dk = (k == 0) ? dout0 : dout1;
                    ck = (k == 0) ? dcnt0 : dcnt1;
                    chk("v_o", k, EW'(v[k]), EW'(cur_v[k]));
                    chk("drop_count_o", k, EW'(ck), EW'(cur_drop[k]));
                    chk("overflow_o", k, EW'(ovf[k]), EW'(cur_ovf[k]));
                    if (yumi[k] && exp_q[k].size() != 0) chk("data_o", k, dk, exp_q[k].pop_front());
                    if (dir_v_en[k]) chk("dir_v_o", k, EW'(v[k]), EW'(dir_v[k]));
                    if (dir_d_en[k]) chk("dir_data_o", k, dk, dir_d[k]);
                    if (dir_drop_en[k]) chk("dir_drop_count_o", k, EW'(ck), EW'(dir_drop[k]));
                end
            end
        end
    end

    initial begin : stim
        int              fp;
        int              yp;
        bit              r;
        logic [CH-1:0]   f;
        logic [CH*W-1:0] d;

        drive(1, 0, '0, '0, 0);
        drive(1, 0, '0, '0, 0);

        // Single capture: enable at cycle 0, ch0 fires at cycle 5
        for (int i = 0; i < 5; i++) drive(0, 1, '0, '0, 0);
        drive(0, 1, 2'b01, 16'h00AB, 0);
        drive(0, 1, '0, '0, 0);
        for (int k = 0; k < 2; k++) expect_v(k, 1'b0);
        drive(0, 1, '0, '0, 0);
        for (int k = 0; k < 2; k++) begin
            expect_v(k, 1'b1);
            expect_d(k, {1'b0, 4'd5, 8'hAB});
        end
        drive(0, 1, '0, '0, 100);
        drive(0, 1, '0, '0, 0);
        for (int k = 0; k < 2; k++) expect_v(k, 1'b0);

        // Back-to-back fires on ch0
        drive(1, 0, '0, '0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, '0, '0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 2'b01, 16'(i + 16'h10), 0);
        for (int i = 0; i < 6; i++) drive(0, 1, '0, '0, 100);
        for (int k = 0; k < 2; k++) expect_drop(k, 0);

        // Contention: both channels fire twice in a row
        drive(1, 0, '0, '0, 0);
        drive(0, 1, '0, '0, 0);
        drive(0, 1, 2'b11, 16'h2211, 0);
        drive(0, 1, 2'b11, 16'h4433, 0);
        drive(0, 1, '0, '0, 0);
        for (int k = 0; k < 2; k++) expect_drop(k, 1);
        for (int i = 0; i < 8; i++) drive(0, 1, '0, '0, 100);

        // Delay counter saturation
        drive(1, 0, '0, '0, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, '0, '0, 0);
        drive(0, 1, 2'b01, 16'h005A, 0);
        drive(0, 1, '0, '0, 0);
        drive(0, 1, '0, '0, 0);
        for (int k = 0; k < 2; k++) expect_d(k, {1'b0, 4'd15, 8'h5A});

        // Six spaced fires into a 4-entry buffer, no draining
        drive(1, 0, '0, '0, 0);
        for (int j = 0; j < 6; j++) begin
            drive(0, 1, 2'b01, 16'(j + 1), 0);
            drive(0, 1, '0, '0, 0);
        end
        drive(0, 1, '0, '0, 0);
        drive(0, 1, '0, '0, 0);
        expect_drop(0, 1);
        expect_drop(1, 2);
        drive(0, 1, '0, '0, 100);
        drive(0, 1, '0, '0, 0);

        // Mid-trace reset with entries stored
        drive(1, 1, '0, '0, 0);
        drive(0, 0, '0, '0, 0);
        for (int k = 0; k < 2; k++) begin
            expect_v(k, 1'b0);
            expect_drop(k, 0);
        end
        for (int i = 0; i < 4; i++) drive(0, 1, '0, '0, 50);

        // Randomized traffic in blocks of varying fire density and drain rate
        for (int blk = 0; blk < 15; blk++) begin
            fp = int'($urandom_range(10, 90));
            yp = int'($urandom_range(0, 100));
            for (int i = 0; i < 200; i++) begin
                r = ($urandom_range(499) == 0);
                for (int c = 0; c < CH; c++) f[c] = (int'($urandom_range(99)) < fp);
                d = (CH*W)'($urandom);
                drive(r, $urandom_range(9) != 0, f, d, yp);
            end
        end
        for (int i = 0; i < 12; i++) drive(0, 0, '0, '0, 100);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_fsb_trace_recorder.md
# bsg_fsb_trace_recorder

Synthesizable, parametrised FSB packet trace recorder. It watches `channels_p` FSB handshake points (node input/output, per node). Each completed transfer is stamped with the idle-cycle delay since the previous transfer on the same channel, and the entries are stored in an on-chip circular trace buffer. A valid/yumi port drains the buffer to a host or scan path, so traces can be captured on silicon rather than only in simulation. Drops are counted and never silent.

## Interface
- `width_p`, 80: packet width (FSB packet).
- `channels_p`, 2: monitored handshake channels (≥1).
- `els_p`, 16: trace buffer entries; power of two, ≥2.
- `counter_width_p`, 16: delay-stamp and drop-counter width.
- `wrap_p`, 0: 0 = stop-when-full, 1 = wrap and overwrite the oldest entry.
- Derived widths:
  - `ch_w` = max(1, clog2(`channels_p`)).
  - `entry_w` = `ch_w` + `counter_width_p` + `width_p`.
  - Entry layout is {channel id (MSBs), delay, packet (LSBs)}.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `en_i` in 1: capture enable.
- `fire_i` in `channels_p`: bit c = transfer completed on channel c this cycle (parent computes v&ready or v&yumi).
- `data_i` in `channels_p`*`width_p`: channel c packet at [c*`width_p` +: `width_p`].
- `v_o` out 1: trace entry available.
- `data_o` out `entry_w`: oldest entry.
- `yumi_i` in 1: consume the oldest entry; legal only while `v_o`=1.
- `drop_count_o` out `counter_width_p`: saturating count of lost captures.
- `overflow_o` out 1: sticky; set on any drop.

## Operation
- **Delay counters (one per channel):**
  - Hold while `en_i`=0.
  - While `en_i`=1: clear to 0 on `fire_i[c]`, otherwise increment, saturating at all-ones.
  - The stamped delay is the counter value in the fire cycle, before the clear.
- **Staging (one holding register per channel):**
  - Condition: `en_i` & `fire_i[c]`.
  - If the holding register is empty, or is granted this same cycle, load {c, delay, packet}.
  - Otherwise drop: `drop_count_o`++ (saturating) and set `overflow_o`.
- **Arbiter:**
  - Round-robin over valid holding registers; at most one grant per cycle.
  - Priority pointer is 0 after reset and moves to one past the granted channel.
  - A grant happens only if the buffer accepts: count<`els_p`, or `yumi_i`=1, or `wrap_p`=1.
- **Buffer:**
  - Flop array with write pointer, read pointer and count 0..`els_p`; pointers wrap modulo `els_p`.
  - Write at the end of the grant cycle.
- **Full buffer, stop mode (`wrap_p`=0):** granting stalls and entries wait in holding. Further fires on a busy channel drop.
- **Full buffer, wrap mode (`wrap_p`=1):**
  - Write with no `yumi_i`: overwrite the oldest entry and advance the read pointer. Count stays `els_p`; `drop_count_o`++ and `overflow_o` set.
  - Write with `yumi_i` in the same cycle: no loss, count unchanged.
- **Readout:** `v_o` = (count≠0); `data_o` = array[read pointer], combinational from flops.
- **`en_i`=0:** no new captures. Staged entries still drain to the buffer and readout continues.
- **Reset (any cycle, including mid-trace):**
  - Pointers, count, holding valids, RR pointer and delay counters go to 0.
  - `v_o`=0, `drop_count_o`=0, `overflow_o`=0.
  - Stored data is discarded.

## Timing
- Fire in cycle t → holding valid at t+1 → granted in t+1 (if uncontested) → `v_o`=1 at t+2. Minimum latency is 2 cycles.
- Aggregate write throughput is 1 entry/cycle; per-channel sustained rate is 1/cycle with no drops.
- `yumi_i` in cycle t frees a slot that a grant can use in the same cycle t.
- `overflow_o` and `drop_count_o` update on the clock edge after the dropping event.

## Test plan
- **Single capture:** `channels_p`=2; `en_i` rises at cycle 0; ch0 fires at cycle 5 with packet 0xAB → `v_o`=1 at cycle 7, `data_o`={0, 5, 0xAB}; `yumi_i` → `v_o`=0.
- **Back-to-back:** ch0 fires at cycles 3, 4, 5 → delays 3, 0, 0 in order; `drop_count_o`=0.
- **Contention:**
  - Stimulus: ch0 and ch1 both fire at t and again at t+1.
  - Output order: ch0(t), ch1(t), ch0(t+1).
  - The ch1 fire at t+1 is dropped: `drop_count_o`=1, `overflow_o`=1.
- **Stop mode:** `els_p`=4, no `yumi_i`; six ch0 fires spaced 2 cycles apart.
  - 4 entries stored, fire 5 is held, fire 6 is dropped (`drop_count_o`=1).
  - One `yumi_i` → fire 5 is written the same cycle and count stays 4.
- **Wrap mode:** `wrap_p`=1, `els_p`=4; six spaced fires → drained entries are fires 3–6, `drop_count_o`=2.
- **Saturation and reset:**
  - `counter_width_p`=4; ch0 fires 20 cycles after enable → delay field 15.
  - Assert `reset_i` with 3 entries stored → next cycle `v_o`=0, counters 0, `overflow_o`=0.
